// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronized rx, oversampled mid-bit sampling, one-cycle strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_error output.
//   state  | meaning
//   IDLE   | line idle, waiting for a low rx_s
//   START  | confirming the start bit at its midpoint
//   DATA   | sampling 8 data bits LSB-first
//   PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
//   STOP   | sampling the stop bit, deciding good byte or framing error
//   BREAK  | line held low after a bad stop bit, waiting for idle
module uart_rx_byte #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_received,
  output logic       rx_data_ready,
  output logic       framing_error,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       busy
);

  localparam int DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] DIV_M1  = TW'(DIV - 1);
  localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1 = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [SW-1:0] samp_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;

  logic samp_clr;
  logic samp_inc;
  logic shift_en;
  logic load_byte;
  logic ferr_set;
`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic par_load;
  logic par_bad;
  logic perr_set;
`endif

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tick_cnt <= '0;
    else if (tick_cnt == DIV_M1) tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + TW'(1);
  end

  assign tick = (tick_cnt == DIV_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

`ifdef UART_RX_PARITY_EN
  assign par_bad = par_q != (^shift_q);
`endif

  always_comb begin
    state_nxt = state;
    samp_clr  = 1'b0;
    samp_inc  = 1'b0;
    shift_en  = 1'b0;
    load_byte = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_load  = 1'b0;
    perr_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          samp_clr  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (samp_cnt == HALF_M1) begin
            samp_clr  = 1'b1;
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            samp_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (samp_cnt == FULL_M1) begin
            samp_clr = 1'b1;
            shift_en = 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end else begin
            samp_inc = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (samp_cnt == FULL_M1) begin
            samp_clr  = 1'b1;
            par_load  = 1'b1;
            state_nxt = STOP;
          end else begin
            samp_inc = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (samp_cnt == FULL_M1) begin
            samp_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_set = par_bad;
`endif
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              load_byte = !par_bad;
`else
              load_byte = 1'b1;
`endif
              state_nxt = IDLE;
            end else begin
              ferr_set  = 1'b1;
              state_nxt = BREAK;
            end
          end else begin
            samp_inc = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           samp_cnt <= '0;
    else if (samp_clr) samp_cnt <= '0;
    else if (samp_inc) samp_cnt <= samp_cnt + SW'(1);
  end

  // bit_idx wraps 7->0 on the last data bit, so it is ready for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
      shift_q <= '0;
    end else if (state == IDLE) begin
      bit_idx <= '0;
    end else if (shift_en) begin
      shift_q[bit_idx] <= rx_s;
      bit_idx          <= bit_idx + 3'd1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           par_q <= 1'b0;
    else if (par_load) par_q <= rx_s;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_received <= 8'h00;
      rx_data_ready <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
    end else begin
      rx_data_ready <= load_byte;
      framing_error <= ferr_set;
`ifdef UART_RX_PARITY_EN
      parity_error  <= perr_set;
`endif
      if (load_byte) byte_received <= shift_q;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 160 clk per bit; define UART_RX_PARITY_EN to run 8E1 cases.
module tb_uart_rx_byte;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int OS       = 16;
  localparam int BIT_CLK  = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] byte_received;
  logic       rx_data_ready;
  logic       framing_error;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
  logic       par_flip = 1'b0;
  int         n_perr = 0;
`endif

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .byte_received (byte_received),
    .rx_data_ready (rx_data_ready),
    .framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
    .parity_error  (parity_error),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_start = 0;
  int t_strobe = 0;
  int n_ready = 0;
  int n_ferr = 0;
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse widths are counted in cycles, so a stuck strobe shows up as an extra count.
  always @(negedge clk) begin
    if (rx_data_ready) begin
      rx_q.push_back(byte_received);
      n_ready++;
      t_strobe = cyc;
    end
    if (framing_error) n_ferr++;
    if (rx_data_ready || framing_error)
      check("ready_ferr_exclusive", {31'b0, rx_data_ready & framing_error}, 32'd0);
`ifdef UART_RX_PARITY_EN
    if (parity_error) n_perr++;
`endif
  end

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    t_start = cyc;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (BIT_CLK) @(negedge clk);
`endif
    rx = stop;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1;
  endtask

  function automatic logic [7:0] pop_byte();
    logic [7:0] b;
    b = 8'hxx;
    if (rx_q.size() > 0) b = rx_q.pop_front();
    return b;
  endfunction

  initial begin
    int r0;
    int f0;
    int lat;
    int busy_cyc;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_byte", byte_received, 8'h00);
    check("rst_ready", rx_data_ready, 0);
    check("rst_ferr", framing_error, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // single byte with latency window: 151 ticks after the first START tick plus sync
    r0 = n_ready;
    send_frame(8'h72, 1'b1);
    repeat (20) @(negedge clk);
    lat = t_strobe - t_start;
    check("r_count", n_ready - r0, 1);
    check("r_byte", byte_received, 8'h72);
    check("r_queue", pop_byte(), 8'h72);
    check("r_latency_ok", (lat >= 1512 && lat <= 1526), 1);
    check("r_ferr", n_ferr, 0);
    check("r_idle", busy, 0);

    r0 = n_ready;
    send_frame(8'h72, 1'b1);
    send_frame(8'h61, 1'b1);
    send_frame(8'h0A, 1'b1);
    repeat (40) @(negedge clk);
    check("b2b_count", n_ready - r0, 3);
    check("b2b_0", pop_byte(), 8'h72);
    check("b2b_1", pop_byte(), 8'h61);
    check("b2b_2", pop_byte(), 8'h0A);
    check("b2b_byte", byte_received, 8'h0A);

    r0 = n_ready;
    busy_cyc = 0;
    rx = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_cyc++;
    end
    rx = 1'b1;
    repeat (160) begin
      @(negedge clk);
      if (busy) busy_cyc++;
    end
    check("glitch_busy_le80", busy_cyc <= 80, 1);
    check("glitch_busy_seen", busy_cyc > 0, 1);
    check("glitch_no_strobe", n_ready - r0, 0);
    check("glitch_idle", busy, 0);

    r0 = n_ready;
    f0 = n_ferr;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (3 * BIT_CLK) @(negedge clk);
    check("break_busy", busy, 1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("ferr_pulse", n_ferr - f0, 1);
    check("ferr_no_ready", n_ready - r0, 0);
    check("ferr_byte_kept", byte_received, 8'h0A);
    check("ferr_idle", busy, 0);
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("after_ferr_count", n_ready - r0, 1);
    check("after_ferr_byte", pop_byte(), 8'hA5);

    // interrupted byte has bits 4..7 high so the tail of the frame looks like idle
    r0 = n_ready;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (5 * BIT_CLK + 80) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_byte", byte_received, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_ready", rx_data_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (100) @(negedge clk);
    check("midrst_no_strobe", n_ready - r0, 0);
    check("midrst_idle", busy, 0);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("after_rst_count", n_ready - r0, 1);
    check("after_rst_byte", pop_byte(), 8'h3C);

`ifdef UART_RX_PARITY_EN
    r0 = n_ready;
    f0 = n_perr;
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    check("par_ok_ready", n_ready - r0, 1);
    check("par_ok_byte", pop_byte(), 8'h07);
    check("par_ok_perr", n_perr - f0, 0);
    r0 = n_ready;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    par_flip = 1'b0;
    check("par_bad_perr", n_perr - f0, 1);
    check("par_bad_no_ready", n_ready - r0, 0);
    check("par_bad_byte", byte_received, 8'h07);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial-to-parallel UART receiver (8N1) feeding the BRAM write controller.
- Synchronizes the asynchronous rx pin and oversamples each bit.
- Presents each received byte on byte_received with a single-cycle rx_data_ready strobe.
- Flags framing errors; never strobes rx_data_ready for a corrupt frame.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- byte_received  output  8  last good byte; held until the next good byte.
- rx_data_ready  output  1  one-cycle pulse when byte_received is updated.
- framing_error  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high while the FSM is outside IDLE.

Behaviour:
- Reset values: byte_received=8'h00, rx_data_ready=0, framing_error=0, busy=0, FSM=IDLE, synchronizer=2'b11, all counters 0.
- Reset asserted mid-frame aborts the frame immediately; no strobe is emitted.
- Synchronizer: 2-FF chain on rx. rx_s is the second stage. rx_s is the only sample source.
- Tick divider:
  - DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), integer-rounded.
  - Free-running counter 0..DIV-1; tick=1 for one clk when the counter equals DIV-1.
  - Size the counter with $clog2(DIV).
- Sample counter: $clog2(OVERSAMPLE) bits, counts ticks; reset to 0 on every state change.
- Bit index: 3 bits, 0..7.
- FSM states:
  - IDLE: on rx_s==0, go to START.
  - START: at tick count OVERSAMPLE/2-1 (mid start bit), resample rx_s. If 0, go to DATA with sample counter cleared. If 1, this is a glitch; return to IDLE.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift rx_s into the shift register LSB-first at bit index. After bit 7, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: byte_received <= shift register; pulse rx_data_ready on the following clk; go to IDLE.
    - If 0: pulse framing_error; byte_received unchanged; go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. Prevents false starts inside a held-low line.
- Latency: rx_data_ready rises 1 clk after the mid-stop-bit sample.
  - Start edge to strobe is about 9.5 bit times, plus 2 synchronizer clks, plus up to 1 tick of jitter.
- Back-to-back frames: a new start bit may fall immediately after the mid-stop sample. IDLE accepts it on the cycle the FSM returns to IDLE.
- rx_data_ready and framing_error are never high in the same cycle.
- busy=1 in START, DATA, STOP and BREAK.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined (8E1 framing):
  - A PARITY state sits between DATA and STOP and samples the mid-bit.
  - Expected parity = XOR of the data bits (even parity).
  - Adds output port parity_error (1 bit, reset 0). It pulses together with the stop-bit decision when parity mismatches.
  - On a parity mismatch, rx_data_ready is suppressed and byte_received is unchanged.
- Undefined: 8N1 framing; there is no PARITY state and no parity_error port.

Test Plan (sim parameters CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit):
- Reset, then send 8'h72 ('r') -> exactly one rx_data_ready pulse; byte_received=8'h72 ~1520+2 clk after the start edge; framing_error stays 0.
- Send "ra\n" back-to-back with no idle gap -> three strobes with values 8'h72, 8'h61, 8'h0A in order; no byte lost.
- Low glitch of 40 clk on idle rx -> FSM returns to IDLE; no strobe; busy high for at most 80 clk.
- Send 8'h55 with the stop bit driven low, then rx held low for 3 bit times, then high -> framing_error single pulse; no rx_data_ready; byte_received keeps its previous value; the next frame 8'hA5 is received correctly.
- Assert rst for 3 clk during bit 4 of a frame -> outputs return to reset values at once; the remainder of the frame causes no strobe; the next frame 8'h3C is received correctly.
- With UART_RX_PARITY_EN: send 8'h07 with parity bit 1 -> rx_data_ready. Send 8'h07 with parity bit 0 -> parity_error pulse and no rx_data_ready.
